// File: rtl/commit_trace_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | commit_trace_tx: buffers writeback commits and streams 10-byte packets    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module commit_trace_tx #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit_valid,
  input  logic [31:0]              commit_pc,
  input  logic [4:0]               commit_rd,
  input  logic [31:0]              commit_data,
  input  logic                     commit_we,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     overflow,
  output logic [7:0]               drop_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   C_FULL  = (AW+1)'(DEPTH);
  localparam logic [7:0]    C_SYNC  = 8'hA5;
  localparam logic [3:0]    C_LAST  = 4'd9;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  // Entry layout {we, rd, pc, data}.
  logic [69:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_q, drop_d;

  state_t        state_q;
  logic [3:0]    idx_q;
  logic [71:0]   shift_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;

  logic          w_hs;
  logic          w_last;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [69:0]   w_head;
  logic [71:0]   w_head_bytes;

  always_comb begin
    w_hs    = tx_valid_q & tx_ready;
    w_last  = (idx_q == C_LAST);
    w_empty = (level_q == '0);
    w_full  = (level_q == C_FULL);
    // Pop when idle, or on the edge that retires the final byte of a packet.
    w_pop   = !w_empty &&
              ((state_q == S_IDLE) || ((state_q == S_SEND) && w_hs && w_last));
    w_push  = commit_valid && (!w_full || w_pop);
    w_drop  = commit_valid && !w_push;

    w_head       = mem_q[rd_ptr_q];
    // Bytes 1..9 of the packet, byte 1 in the low octet; byte 0 is the sync.
    w_head_bytes = {w_head[31:0], w_head[63:32], w_head[69], 2'b00, w_head[68:64]};
  end

  always_comb begin
    wr_ptr_d   = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d    = level_q;
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    overflow_d = overflow_q | w_drop;
    drop_d     = (w_drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {commit_we, commit_rd, commit_pc, commit_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      shift_q    <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_pop) begin
            state_q    <= S_SEND;
            idx_q      <= 4'd0;
            shift_q    <= w_head_bytes;
            tx_data_q  <= C_SYNC;
            tx_valid_q <= 1'b1;
          end
        end
        S_SEND: begin
          if (w_hs) begin
            if (!w_last) begin
              idx_q     <= idx_q + 4'd1;
              tx_data_q <= shift_q[7:0];
              shift_q   <= {8'h00, shift_q[71:8]};
            end else if (w_pop) begin
              idx_q     <= 4'd0;
              shift_q   <= w_head_bytes;
              tx_data_q <= C_SYNC;
            end else begin
              state_q    <= S_IDLE;
              idx_q      <= 4'd0;
              tx_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  assign fifo_level = level_q;

endmodule
`default_nettype wire
